// File: rtl/br_injector_pkg.sv
// BrLite shared types: service codes and the injector scenario record.
package BrLitePkg;

  typedef enum logic [1:0] {
    SVC_TGT = 2'd0,
    SVC_ALL = 2'd1,
    SVC_MC  = 2'd2,
    SVC_CLR = 2'd3
  } br_svc_t;

  // Record timestamps are held at this maximum width; injectors use the low TS_WIDTH bits.
  localparam int unsigned BR_TS_MAX_W = 64;

  typedef struct packed {
    logic [BR_TS_MAX_W-1:0] timestamp;
    logic [31:0]            source;
    logic [31:0]            target;
    logic [31:0]            payload;
    br_svc_t                service;
  } br_inj_rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/br_inj_fifo.sv
// Record buffer for br_injector: power-of-two depth, first-word fall-through head.
module br_inj_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= data_i;
  end

  assign data_o  = mem[rptr[AW-1:0]];
  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/br_injector.sv
// Timestamped BrLite request injector for one PE.
// Define BR_INJ_STATS_EN to build the sent/late statistics counters.
module br_injector
  import BrLitePkg::*;
#(
  parameter int unsigned SOURCE_ID  = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_WIDTH   = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rec_valid_i,
  output logic                rec_ready_o,
  input  logic [TS_WIDTH-1:0] rec_timestamp_i,
  input  logic [31:0]         rec_source_i,
  input  logic [31:0]         rec_target_i,
  input  logic [31:0]         rec_payload_i,
  input  br_svc_t             rec_service_i,
  output logic                br_req_o,
  output logic [31:0]         br_target_o,
  output logic [31:0]         br_payload_o,
  output br_svc_t             br_service_o,
  input  logic                br_ack_i,
  output logic [TS_WIDTH-1:0] now_o,
  output logic [15:0]         sent_cnt_o,
  output logic [15:0]         late_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;

  state_t              state;
  br_inj_rec_t         push_rec;
  br_inj_rec_t         head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                due;
  logic [TS_WIDTH-1:0] head_ts;
  logic                unused_head;

  assign rec_ready_o = !full;
  assign push        = rec_valid_i && rec_ready_o && (rec_source_i == 32'(SOURCE_ID));
  assign pop         = (state == REQ) && br_ack_i;

  always_comb begin
    push_rec                         = '0;
    push_rec.timestamp[TS_WIDTH-1:0] = rec_timestamp_i;
    push_rec.source                  = rec_source_i;
    push_rec.target                  = rec_target_i;
    push_rec.payload                 = rec_payload_i;
    push_rec.service                 = rec_service_i;
  end

  br_inj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(br_inj_rec_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_ts     = head.timestamp[TS_WIDTH-1:0];
  assign due         = (now_o >= head_ts);
  assign unused_head = ^{head.timestamp, head.source};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      now_o <= '0;
    end else if (now_o != '1) begin
      now_o <= now_o + TS_WIDTH'(1);
    end
  end

  // IDLE also reacts to the push itself, so a record enters WAIT the cycle after acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      br_req_o     <= 1'b0;
      br_target_o  <= '0;
      br_payload_o <= '0;
      br_service_o <= SVC_TGT;
    end else begin
      case (state)
        IDLE: if (!empty || push) state <= WAIT;
        WAIT: begin
          if (due) begin
            state        <= REQ;
            br_req_o     <= 1'b1;
            br_target_o  <= head.target;
            br_payload_o <= head.payload;
            br_service_o <= head.service;
          end
        end
        REQ: begin
          if (br_ack_i) begin
            state    <= IDLE;
            br_req_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          br_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_INJ_STATS_EN
  logic        late_issue;
  logic [15:0] sent_q;
  logic [15:0] late_q;

  // Issue is the first cycle with now >= ts, so ts < now here means it was already past at WAIT entry.
  assign late_issue = (state == WAIT) && due && (head_ts < now_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= '0;
      late_q <= '0;
    end else begin
      if (pop)        sent_q <= sat_inc16(sent_q);
      if (late_issue) late_q <= sat_inc16(late_q);
    end
  end

  assign sent_cnt_o = sent_q;
  assign late_cnt_o = late_q;
`else
  assign sent_cnt_o = '0;
  assign late_cnt_o = '0;
`endif

endmodule
